p405s_timer_rst_seq: RTL and testbench



---
 rtl/p405s_timer_rst_seq.sv | 214 +++++++++++++++++++++
 tb/tb_p405s_timer_rst_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p405s_timer_rst_seq.sv
// p405s_timer_rst_seq
// Turns level reset requests from the timer watchdog and from debug into a
// single prioritised, minimum-width, acknowledged reset request toward the
// chip reset logic. It also keeps the type of the most recent reset for the
// debug status register. Only resetCore resets this block. A core reset that
// this block requests does not reset it.
//
// Ports
//   CB               clock
//   resetCore        synchronous active-high reset
//   TIM_wdCoreRst    watchdog core-reset request (level)
//   TIM_wdSysRst     watchdog system-reset request (level)
//   TIM_wdChipRst    watchdog chip-reset request (level)
//   DBG_rstReq       debug request: 00 none, 01 core, 10 chip, 11 system
//   rstAck           acknowledge from the reset logic (level)
//   RST_coreRstReq   core reset request (registered)
//   RST_sysRstReq    system reset request (registered)
//   RST_chipRstReq   chip reset request (registered)
//   RST_mrr          most recent reset type, same code as DBG_rstReq
//   RST_busy         sequencer not idle
//   RST_ackTimeout   sticky: a request was released without an acknowledge
//   dbgState         current sequencer state (0 IDLE, 1 ASSERT, 2 WAIT_ACK, 3 HOLDOFF)
//
// Handshake: a RST_*RstReq output plays the role of "valid". rstAck plays
// the role of "ready". The request stays high for at least HOLD_CYCLES.
// After that it stays high until rstAck is sampled high on a clock edge, or
// until ACK_TIMEOUT cycles pass. The request drops on that same edge.
// rstAck is ignored while the minimum width is still running.
module p405s_timer_rst_seq #(
    parameter int HOLD_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int ACK_TIMEOUT    = 1024,
    parameter int CNT_W          = 11
) (
    input  logic        CB,
    input  logic        resetCore,
    input  logic        TIM_wdCoreRst,
    input  logic        TIM_wdSysRst,
    input  logic        TIM_wdChipRst,
    input  logic [0:1]  DBG_rstReq,
    input  logic        rstAck,
    output logic        RST_coreRstReq,
    output logic        RST_sysRstReq,
    output logic        RST_chipRstReq,
    output logic [0:2]  RST_mrr,
    output logic        RST_busy,
    output logic        RST_ackTimeout,
    output logic [1:0]  dbgState
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ASSERT   = 2'd1,
        WAIT_ACK = 2'd2,
        HOLDOFF  = 2'd3
    } seqState_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLDOFF_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LOAD     = CNT_W'(ACK_TIMEOUT - 1);

    // Rank 1 core, 2 system, 3 chip. The type code is different: chip is 10
    // and system is 11.
    function automatic logic [1:0] rankCode(input logic [1:0] rank);
        case (rank)
            2'd1:    rankCode = 2'b01;
            2'd2:    rankCode = 2'b11;
            2'd3:    rankCode = 2'b10;
            default: rankCode = 2'b00;
        endcase
    endfunction

    function automatic logic [2:0] rankOneHot(input logic [1:0] rank);
        case (rank)
            2'd1:    rankOneHot = 3'b001;
            2'd2:    rankOneHot = 3'b010;
            2'd3:    rankOneHot = 3'b100;
            default: rankOneHot = 3'b000;
        endcase
    endfunction

    // Input stage. Bits [2:0] are TIM core/sys/chip and bits [5:3] are
    // DBG core/sys/chip. The edge register adds one stage, so the total
    // latency from an input change to an asserted output is three edges.
    logic [5:0] reqRaw;
    logic [5:0] reqSample;
    logic [5:0] reqPrev;
    logic [5:0] reqEdge;
    logic [1:0] edgeRank;

    always_comb begin
        reqRaw = {DBG_rstReq == 2'b10, DBG_rstReq == 2'b11, DBG_rstReq == 2'b01,
                  TIM_wdChipRst, TIM_wdSysRst, TIM_wdCoreRst};
    end

    always_ff @(posedge CB) begin
        if (resetCore) begin
            reqSample <= '0;
            reqPrev   <= '0;
            reqEdge   <= '0;
        end else begin
            reqSample <= reqRaw;
            reqPrev   <= reqSample;
            reqEdge   <= reqSample & ~reqPrev;
        end
    end

    // The sources are OR-ed after edge detection. When several edges arrive
    // together, only the highest rank survives.
    always_comb begin
        if (reqEdge[2] | reqEdge[5])      edgeRank = 2'd3;
        else if (reqEdge[1] | reqEdge[4]) edgeRank = 2'd2;
        else if (reqEdge[0] | reqEdge[3]) edgeRank = 2'd1;
        else                              edgeRank = 2'd0;
    end

    // Sequencer
    seqState_t        state, stateN;
    logic [CNT_W-1:0] cnt, cntN;
    logic [1:0]       activeRank, activeN;
    logic [1:0]       pendRank, pendN;
    logic [1:0]       selRank;
    logic [2:0]       reqOut, reqN;
    logic [2:0]       mrr, mrrN;
    logic             busy, busyN;
    logic             ackTo, ackToN;

    always_ff @(posedge CB) begin
        if (resetCore) begin
            state      <= IDLE;
            cnt        <= '0;
            activeRank <= 2'd0;
            pendRank   <= 2'd0;
            reqOut     <= 3'b000;
            mrr        <= 3'b000;
            busy       <= 1'b0;
            ackTo      <= 1'b0;
        end else begin
            state      <= stateN;
            cnt        <= cntN;
            activeRank <= activeN;
            pendRank   <= pendN;
            reqOut     <= reqN;
            mrr        <= mrrN;
            busy       <= busyN;
            ackTo      <= ackToN;
        end
    end

    always_comb begin
        stateN  = state;
        cntN    = (cnt != '0) ? cnt - 1'b1 : cnt;  // saturate at zero
        activeN = activeRank;
        pendN   = pendRank;
        mrrN    = mrr;
        ackToN  = ackTo;
        selRank = (pendRank > edgeRank) ? pendRank : edgeRank;

        case (state)
            IDLE: begin
                if (selRank != 2'd0) begin
                    stateN  = ASSERT;
                    cntN    = HOLD_LOAD;
                    activeN = selRank;
                    mrrN    = {1'b0, rankCode(selRank)};
                    pendN   = 2'd0;
                end
            end
            ASSERT, WAIT_ACK: begin
                // A strictly higher rank takes over at once. This has
                // priority over an acknowledge or timeout on the same edge.
                if (edgeRank > activeRank) begin
                    stateN  = ASSERT;
                    cntN    = HOLD_LOAD;
                    activeN = edgeRank;
                    mrrN    = {1'b0, rankCode(edgeRank)};
                end else if (state == ASSERT) begin
                    if (cnt == '0) begin
                        stateN = WAIT_ACK;
                        cntN   = ACK_LOAD;
                    end
                end else if (rstAck) begin
                    stateN  = HOLDOFF;
                    cntN    = HOLDOFF_LOAD;
                    activeN = 2'd0;
                end else if (cnt == '0) begin
                    stateN  = HOLDOFF;
                    cntN    = HOLDOFF_LOAD;
                    activeN = 2'd0;
                    ackToN  = 1'b1;
                end
            end
            HOLDOFF: begin
                // Edges seen here are kept, including on the exit edge.
                // They are served on the IDLE cycle that follows.
                if (edgeRank > pendRank) pendN = edgeRank;
                if (cnt == '0) stateN = IDLE;
            end
            default: stateN = IDLE;
        endcase

        reqN  = rankOneHot(activeN);
        busyN = (stateN != IDLE);
    end

    assign RST_coreRstReq = reqOut[0];
    assign RST_sysRstReq  = reqOut[1];
    assign RST_chipRstReq = reqOut[2];
    assign RST_mrr        = mrr;
    assign RST_busy       = busy;
    assign RST_ackTimeout = ackTo;
    assign dbgState       = state;

endmodule

// File: tb/tb_p405s_timer_rst_seq.sv
// Bench for p405s_timer_rst_seq. A timeline model predicts the outputs from
// absolute edge numbers: when each request is accepted, when it drops, and
// when the holdoff ends. Directed scenarios drive the inputs and also pin key
// timings with literal values.
module tb_p405s_timer_rst_seq;

    localparam int HOLD    = 16;
    localparam int HOLDOFF = 8;
    localparam int ACKTO   = 1024;

    logic       CB = 1'b0;
    logic       resetCore = 1'b1;
    logic       TIM_wdCoreRst = 1'b0;
    logic       TIM_wdSysRst = 1'b0;
    logic       TIM_wdChipRst = 1'b0;
    logic [0:1] DBG_rstReq = 2'b00;
    logic       rstAck = 1'b0;
    logic       RST_coreRstReq;
    logic       RST_sysRstReq;
    logic       RST_chipRstReq;
    logic [0:2] RST_mrr;
    logic       RST_busy;
    logic       RST_ackTimeout;
    logic [1:0] dbgState;

    int compared = 0;
    int mismatched = 0;

    p405s_timer_rst_seq #(
        .HOLD_CYCLES(HOLD), .HOLDOFF_CYCLES(HOLDOFF), .ACK_TIMEOUT(ACKTO), .CNT_W(11)
    ) dut (
        .CB(CB), .resetCore(resetCore),
        .TIM_wdCoreRst(TIM_wdCoreRst), .TIM_wdSysRst(TIM_wdSysRst),
        .TIM_wdChipRst(TIM_wdChipRst), .DBG_rstReq(DBG_rstReq), .rstAck(rstAck),
        .RST_coreRstReq(RST_coreRstReq), .RST_sysRstReq(RST_sysRstReq),
        .RST_chipRstReq(RST_chipRstReq), .RST_mrr(RST_mrr), .RST_busy(RST_busy),
        .RST_ackTimeout(RST_ackTimeout), .dbgState(dbgState)
    );

    // Clock
    always #5 CB = ~CB;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model
    logic [7:0] expQ[$];
    bit [5:0]   hist [8192];
    int         edgeN = 0;
    int         lastRst = -100;
    int         activeRank = 0;
    int         startE = 0;
    int         dropE = -100000;
    int         pendRank = 0;
    logic [2:0] mMrr = 3'b000;
    logic       mTo = 1'b0;

    function automatic logic [2:0] typeCode(input int r);
        case (r)
            1:       return 3'b001;
            2:       return 3'b011;
            3:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic modelStep();
        bit [5:0] rise;
        int ev;
        int r;
        edgeN++;
        if (resetCore) begin
            hist[edgeN % 8192] = '0;
            lastRst    = edgeN;
            activeRank = 0;
            pendRank   = 0;
            dropE      = -100000;
            mMrr       = 3'b000;
            mTo        = 1'b0;
        end else begin
            hist[edgeN % 8192] = {DBG_rstReq == 2'b10, DBG_rstReq == 2'b11, DBG_rstReq == 2'b01,
                                  TIM_wdChipRst, TIM_wdSysRst, TIM_wdCoreRst};
            // An input level seen on edge n acts on edge n+2.
            rise = '0;
            if (edgeN > lastRst + 2 && edgeN >= 4)
                rise = hist[(edgeN - 2) % 8192] & ~hist[(edgeN - 3) % 8192];
            ev = 0;
            if (rise[0] || rise[3]) ev = 1;
            if (rise[1] || rise[4]) ev = 2;
            if (rise[2] || rise[5]) ev = 3;
            if (activeRank != 0) begin
                if (ev > activeRank) begin
                    activeRank = ev;
                    startE = edgeN;
                    mMrr = typeCode(ev);
                end else if (rstAck && edgeN >= startE + HOLD + 1) begin
                    activeRank = 0;
                    dropE = edgeN;
                end else if (edgeN >= startE + HOLD + ACKTO) begin
                    activeRank = 0;
                    dropE = edgeN;
                    mTo = 1'b1;
                end
            end else if (edgeN <= dropE + HOLDOFF) begin
                if (ev > pendRank) pendRank = ev;
            end else begin
                r = (pendRank > ev) ? pendRank : ev;
                if (r != 0) begin
                    activeRank = r;
                    startE = edgeN;
                    mMrr = typeCode(r);
                end
                pendRank = 0;
            end
        end
        expQ.push_back({activeRank == 1, activeRank == 2, activeRank == 3, mMrr,
                        (activeRank != 0) || (edgeN < dropE + HOLDOFF), mTo});
    endtask

    initial begin
        forever begin
            @(posedge CB);
            modelStep();
        end
    end

    // Scoreboard: every cycle, compare the DUT against the model
    initial begin
        logic [7:0] exp;
        forever begin
            @(negedge CB);
            if (expQ.size() == 0) begin
                if (edgeN > 0) chk("model_queue_empty", 32'd0, 32'd1);
            end else begin
                exp = expQ.pop_front();
                chk("cycle_outputs",
                    {24'd0, RST_coreRstReq, RST_sysRstReq, RST_chipRstReq, RST_mrr,
                     RST_busy, RST_ackTimeout}, {24'd0, exp});
            end
        end
    end

    // Driver
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CB);
            #2;
        end
    endtask

    // Directed scenarios
    initial begin
        int highCnt;

        // Reset
        tick(3);
        chk("rst_core", RST_coreRstReq, 0);
        chk("rst_sys", RST_sysRstReq, 0);
        chk("rst_chip", RST_chipRstReq, 0);
        chk("rst_mrr", RST_mrr, 0);
        chk("rst_busy", RST_busy, 0);
        chk("rst_to", RST_ackTimeout, 0);
        resetCore = 1'b0;
        tick(4);

        // 1: a core request is acknowledged after the minimum width
        TIM_wdCoreRst = 1'b1;
        tick(2);
        chk("t1_lat_low", RST_coreRstReq, 0);
        tick();
        chk("t1_lat_high", RST_coreRstReq, 1);
        chk("t1_mrr", RST_mrr, 3'b001);
        tick(27);
        chk("t1_hold", RST_coreRstReq, 1);
        rstAck = 1'b1;
        tick();
        chk("t1_drop", RST_coreRstReq, 0);
        chk("t1_busy_hold", RST_busy, 1);
        rstAck = 1'b0;
        TIM_wdCoreRst = 1'b0;
        tick(7);
        chk("t1_busy_last", RST_busy, 1);
        tick();
        chk("t1_busy_low", RST_busy, 0);
        tick(3);

        // 2: system and chip edges arrive together; chip wins
        TIM_wdSysRst = 1'b1;
        DBG_rstReq = 2'b10;
        tick(3);
        chk("t2_chip", RST_chipRstReq, 1);
        chk("t2_sys", RST_sysRstReq, 0);
        chk("t2_mrr", RST_mrr, 3'b010);
        tick(20);
        rstAck = 1'b1;
        tick();
        chk("t2_drop", RST_chipRstReq, 0);
        rstAck = 1'b0;
        TIM_wdSysRst = 1'b0;
        DBG_rstReq = 2'b00;
        tick(10);
        chk("t2_no_sys", RST_sysRstReq, 0);
        chk("t2_idle", RST_busy, 0);

        // 3: a chip request escalates over a core request waiting for ack
        TIM_wdCoreRst = 1'b1;
        tick(3);
        chk("t3_core", RST_coreRstReq, 1);
        tick(20);
        TIM_wdChipRst = 1'b1;
        tick(2);
        chk("t3_core_before", RST_coreRstReq, 1);
        tick();
        chk("t3_core_gone", RST_coreRstReq, 0);
        chk("t3_chip_up", RST_chipRstReq, 1);
        chk("t3_mrr", RST_mrr, 3'b010);
        tick(15);
        rstAck = 1'b1;
        tick();
        chk("t3_min_width", RST_chipRstReq, 1);
        tick();
        chk("t3_released", RST_chipRstReq, 0);
        rstAck = 1'b0;
        TIM_wdCoreRst = 1'b0;
        TIM_wdChipRst = 1'b0;
        tick(10);

        // 5: a debug core edge during holdoff is served after one idle cycle
        TIM_wdSysRst = 1'b1;
        tick(3);
        chk("t5_sys", RST_sysRstReq, 1);
        chk("t5_mrr_sys", RST_mrr, 3'b011);
        tick(17);
        rstAck = 1'b1;
        tick();
        chk("t5_sys_drop", RST_sysRstReq, 0);
        rstAck = 1'b0;
        TIM_wdSysRst = 1'b0;
        DBG_rstReq = 2'b01;
        tick(8);
        chk("t5_idle_gap", RST_busy, 0);
        chk("t5_core_wait", RST_coreRstReq, 0);
        tick();
        chk("t5_pending", RST_coreRstReq, 1);
        chk("t5_mrr_core", RST_mrr, 3'b001);
        tick(17);
        rstAck = 1'b1;
        tick();
        rstAck = 1'b0;
        tick(30);
        chk("t5_no_repeat", RST_coreRstReq, 0);
        chk("t5_quiet", RST_busy, 0);
        DBG_rstReq = 2'b00;
        tick(3);

        // 4: without an ack the request is released by timeout
        chk("t4_to_clear", RST_ackTimeout, 0);
        TIM_wdCoreRst = 1'b1;
        tick(3);
        highCnt = 0;
        if (RST_coreRstReq) highCnt = 1;
        for (int i = 0; i < 1200 && RST_coreRstReq; i++) begin
            tick();
            if (RST_coreRstReq) highCnt++;
        end
        chk("t4_width", highCnt, HOLD + ACKTO);
        chk("t4_to_set", RST_ackTimeout, 1);
        TIM_wdCoreRst = 1'b0;
        tick(12);
        chk("t4_to_sticky", RST_ackTimeout, 1);
        chk("t4_idle", RST_busy, 0);

        // 6: resetCore during ASSERT, with the chip level held through reset
        TIM_wdChipRst = 1'b1;
        tick(3);
        chk("t6_chip", RST_chipRstReq, 1);
        tick(3);
        resetCore = 1'b1;
        tick();
        chk("t6_rst_chip", RST_chipRstReq, 0);
        chk("t6_rst_mrr", RST_mrr, 0);
        chk("t6_rst_to", RST_ackTimeout, 0);
        chk("t6_rst_busy", RST_busy, 0);
        tick();
        resetCore = 1'b0;
        tick(2);
        chk("t6_retrig_wait", RST_chipRstReq, 0);
        tick();
        chk("t6_retrig", RST_chipRstReq, 1);
        chk("t6_retrig_mrr", RST_mrr, 3'b010);
        rstAck = 1'b1;
        tick(20);
        rstAck = 1'b0;
        TIM_wdChipRst = 1'b0;
        tick(12);
        chk("t6_end_idle", RST_busy, 0);

        @(negedge CB);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
